pipeline_hazard_ctrl: RTL and testbench

//  Parametrised successor to the pipeline hazard controller. Central stall/flush generator for an
//  N-stage in-order pipeline. Per-register countdown scoreboard covers variable-latency producers:
//  ALU, load and multicycle units. Adds multi-cycle branch-bubble insertion and mispredict squash.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 16 +
 rtl/pipeline_hazard_ctrl_if.sv | 45 ++++
 rtl/pipeline_hazard_ctrl_scoreboard.sv | 56 +++++
 rtl/pipeline_hazard_ctrl.sv | 103 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and default geometry for the pipeline hazard controller.
// Optional feature macro used by this slice: HAZARD_PERF_CNT_EN.
package pipeline_ctrl_pkg;

    localparam int DEF_STAGE_NUM = 5;
    localparam int DEF_REG_NUM   = 32;
    localparam int DEF_MAX_LAT   = 8;
    localparam int DEF_REG_W     = $clog2(DEF_REG_NUM);
    localparam int DEF_LAT_W     = $clog2(DEF_MAX_LAT + 1);
    localparam int REG_ZERO      = 0;

    typedef logic [DEF_STAGE_NUM-1:0] StageVec;
    typedef logic [DEF_REG_W-1:0]     RegAddr;
    typedef logic [DEF_LAT_W-1:0]     Latency;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Issue/branch inputs and stall/flush outputs between the pipeline and its hazard controller.
// With HAZARD_PERF_CNT_EN defined the interface also carries the performance counters.
interface pipeline_hazard_ctrl_if #(
    parameter int STAGE_NUM = 5,
    parameter int REG_W     = 5,
    parameter int LAT_W     = 4
);
    logic                 issueValid;
    logic [REG_W-1:0]     issueRs1Addr;
    logic                 issueRs1Used;
    logic [REG_W-1:0]     issueRs2Addr;
    logic                 issueRs2Used;
    logic [REG_W-1:0]     issueRdAddr;
    logic                 issueRdWen;
    logic [LAT_W-1:0]     issueLatency;
    logic                 predBranchTaken;
    logic                 missValid;
    logic [STAGE_NUM-1:0] stageStall;
    logic [STAGE_NUM-1:0] stageFlush;
    logic                 dataHazard;
    logic                 branchBubble;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]          perfStallCycles;
    logic [31:0]          perfBubbleCycles;
    logic [31:0]          perfMissCount;
`endif

    modport master (
        output issueValid, issueRs1Addr, issueRs1Used, issueRs2Addr, issueRs2Used,
               issueRdAddr, issueRdWen, issueLatency, predBranchTaken, missValid,
        input  stageStall, stageFlush, dataHazard, branchBubble
`ifdef HAZARD_PERF_CNT_EN
        , input perfStallCycles, perfBubbleCycles, perfMissCount
`endif
    );

    modport slave (
        input  issueValid, issueRs1Addr, issueRs1Used, issueRs2Addr, issueRs2Used,
               issueRdAddr, issueRdWen, issueLatency, predBranchTaken, missValid,
        output stageStall, stageFlush, dataHazard, branchBubble
`ifdef HAZARD_PERF_CNT_EN
        , output perfStallCycles, perfBubbleCycles, perfMissCount
`endif
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// Per-register countdown scoreboard: cycles until each destination becomes bypassable,
// plus the combinational read-after-write hazard check for the issuing instruction.
module hazard_scoreboard
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_NUM = DEF_REG_NUM,
    parameter int REG_W   = DEF_REG_W,
    parameter int LAT_W   = DEF_LAT_W
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             issueValid,
    input  logic [REG_W-1:0] rs1Addr,
    input  logic             rs1Used,
    input  logic [REG_W-1:0] rs2Addr,
    input  logic             rs2Used,
    input  logic [REG_W-1:0] rdAddr,
    input  logic             rdWen,
    input  logic [LAT_W-1:0] latency,
    input  logic             missValid,
    output logic             dataHazard
);

    logic [LAT_W-1:0] pending [REG_NUM];
    logic             accept;

    function automatic logic [LAT_W-1:0] decSat(input logic [LAT_W-1:0] v);
        return (v != '0) ? v - LAT_W'(1) : '0;
    endfunction

    function automatic logic [LAT_W-1:0] maxLat(input logic [LAT_W-1:0] a, input logic [LAT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    always_comb begin
        dataHazard = issueValid && !missValid &&
                     ((rs1Used && (pending[rs1Addr] != '0)) ||
                      (rs2Used && (pending[rs2Addr] != '0)));
        accept     = issueValid && !dataHazard && !missValid;
    end

    // Entries age every cycle regardless of stalls; a new producer never shortens an older wait.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            for (int r = 0; r < REG_NUM; r++) pending[r] <= '0;
        end else begin
            for (int r = 0; r < REG_NUM; r++) begin
                if (accept && rdWen && (r != REG_ZERO) && (rdAddr == REG_W'(r)))
                    pending[r] <= maxLat(latency - LAT_W'(1), decSat(pending[r]));
                else
                    pending[r] <= decSat(pending[r]);
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush generator: scoreboard hazards, branch bubbles and mispredict squash.
// Define HAZARD_PERF_CNT_EN to add the stall/bubble/miss performance counters.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int STAGE_NUM     = DEF_STAGE_NUM,
    parameter int DEC_STAGE     = 1,
    parameter int CONFIRM_STAGE = 2,
    parameter int REG_NUM       = DEF_REG_NUM,
    parameter int MAX_LAT       = DEF_MAX_LAT,
    parameter int BR_BUBBLE     = 1
) (
    input logic                   clk,
    input logic                   rstN,
    pipeline_hazard_ctrl_if.slave hif
);

    localparam int REG_W = $clog2(REG_NUM);
    localparam int LAT_W = $clog2(MAX_LAT + 1);
    localparam int BUB_W = (BR_BUBBLE > 1) ? $clog2(BR_BUBBLE + 1) : 1;
    localparam int SQUASH_IDX = (DEC_STAGE > 0) ? DEC_STAGE - 1 : 0;

    logic                 hazardRaw;
    logic [BUB_W-1:0]     bubbleCnt;
    logic [STAGE_NUM-1:0] stall;
    logic [STAGE_NUM-1:0] flush;

    hazard_scoreboard #(
        .REG_NUM (REG_NUM),
        .REG_W   (REG_W),
        .LAT_W   (LAT_W)
    ) uScoreboard (
        .clk        (clk),
        .rstN       (rstN),
        .issueValid (hif.issueValid),
        .rs1Addr    (hif.issueRs1Addr),
        .rs1Used    (hif.issueRs1Used),
        .rs2Addr    (hif.issueRs2Addr),
        .rs2Used    (hif.issueRs2Used),
        .rdAddr     (hif.issueRdAddr),
        .rdWen      (hif.issueRdWen),
        .latency    (hif.issueLatency),
        .missValid  (hif.missValid),
        .dataHazard (hazardRaw)
    );

    // Bubbles only drain while decode is moving, so each one squashes a distinct fetch slot.
    always_ff @(posedge clk) begin
        if (!rstN)
            bubbleCnt <= '0;
        else if (hif.missValid)
            bubbleCnt <= '0;
        else if (hif.predBranchTaken)
            bubbleCnt <= BUB_W'(BR_BUBBLE);
        else if ((bubbleCnt != '0) && !hazardRaw)
            bubbleCnt <= bubbleCnt - BUB_W'(1);
    end

    always_comb begin
        stall = '0;
        flush = '0;
        if (!rstN) begin
            flush = '1;
        end else if (hif.missValid) begin
            for (int i = 0; i < STAGE_NUM; i++)
                if (i < CONFIRM_STAGE) flush[i] = 1'b1;
        end else if (hazardRaw) begin
            for (int i = 0; i < STAGE_NUM; i++)
                if (i <= DEC_STAGE) stall[i] = 1'b1;
            flush[DEC_STAGE] = 1'b1;
        end else if ((bubbleCnt != '0) && (BR_BUBBLE > 0)) begin
            flush[SQUASH_IDX] = 1'b1;
        end
    end

    assign hif.stageStall   = stall;
    assign hif.stageFlush   = flush;
    assign hif.dataHazard   = rstN && hazardRaw;
    assign hif.branchBubble = rstN && (bubbleCnt != '0);

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perfStall;
    logic [31:0] perfBubble;
    logic [31:0] perfMiss;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            perfStall  <= '0;
            perfBubble <= '0;
            perfMiss   <= '0;
        end else begin
            if (hazardRaw)          perfStall  <= perfStall + 32'd1;
            if (bubbleCnt != '0)    perfBubble <= perfBubble + 32'd1;
            if (hif.missValid)      perfMiss   <= perfMiss + 32'd1;
        end
    end

    assign hif.perfStallCycles  = perfStall;
    assign hif.perfBubbleCycles = perfBubble;
    assign hif.perfMissCount    = perfMiss;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios then random traffic against a reference
// model; two instances (BR_BUBBLE=1 and BR_BUBBLE=2) share the same stimulus.
module tb_pipeline_hazard_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam int SN   = 5;
    localparam int DEC  = 1;
    localparam int CONF = 2;
    localparam int B1   = 1;
    localparam int B2   = 2;

    logic   clk = 1'b0;
    always #5 clk = ~clk;

    logic   rstN;
    logic   issueValid, rs1u, rs2u, wen, pred, miss;
    RegAddr rs1, rs2, rd;
    Latency lat;

    pipeline_hazard_ctrl_if #(.STAGE_NUM(SN), .REG_W(DEF_REG_W), .LAT_W(DEF_LAT_W)) hif1 ();
    pipeline_hazard_ctrl_if #(.STAGE_NUM(SN), .REG_W(DEF_REG_W), .LAT_W(DEF_LAT_W)) hif2 ();

    assign hif1.issueValid = issueValid;   assign hif2.issueValid = issueValid;
    assign hif1.issueRs1Addr = rs1;        assign hif2.issueRs1Addr = rs1;
    assign hif1.issueRs1Used = rs1u;       assign hif2.issueRs1Used = rs1u;
    assign hif1.issueRs2Addr = rs2;        assign hif2.issueRs2Addr = rs2;
    assign hif1.issueRs2Used = rs2u;       assign hif2.issueRs2Used = rs2u;
    assign hif1.issueRdAddr = rd;          assign hif2.issueRdAddr = rd;
    assign hif1.issueRdWen = wen;          assign hif2.issueRdWen = wen;
    assign hif1.issueLatency = lat;        assign hif2.issueLatency = lat;
    assign hif1.predBranchTaken = pred;    assign hif2.predBranchTaken = pred;
    assign hif1.missValid = miss;          assign hif2.missValid = miss;

    pipeline_hazard_ctrl #(.STAGE_NUM(SN), .DEC_STAGE(DEC), .CONFIRM_STAGE(CONF),
                           .REG_NUM(32), .MAX_LAT(8), .BR_BUBBLE(B1))
        dut1 (.clk(clk), .rstN(rstN), .hif(hif1));
    pipeline_hazard_ctrl #(.STAGE_NUM(SN), .DEC_STAGE(DEC), .CONFIRM_STAGE(CONF),
                           .REG_NUM(32), .MAX_LAT(8), .BR_BUBBLE(B2))
        dut2 (.clk(clk), .rstN(rstN), .hif(hif2));

    // Reference state: remaining wait per register, outstanding bubbles per instance.
    int pend [32];
    int bub1, bub2;
    int passCnt = 0;
    int totalCnt = 0;

    logic    lastHz, lastBb2;
    StageVec lastStall1, lastFlush1, lastFlush2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit modelHz();
        if (!rstN || !issueValid || miss) return 1'b0;
        return (rs1u && pend[rs1] > 0) || (rs2u && pend[rs2] > 0);
    endfunction

    function automatic StageVec modelFlush(input int b);
        if (!rstN)     return StageVec'((1 << SN) - 1);
        if (miss)      return StageVec'((1 << CONF) - 1);
        if (modelHz()) return StageVec'(1 << DEC);
        if (b > 0)     return StageVec'(1 << (DEC - 1));
        return StageVec'(0);
    endfunction

    function automatic StageVec modelStall();
        if (rstN && !miss && modelHz()) return StageVec'((1 << (DEC + 1)) - 1);
        return StageVec'(0);
    endfunction

    task automatic cycle();
        bit hz, acc;
        int old, nv;
        @(negedge clk);
        hz = modelHz();
        chk("hazard1", 32'(hif1.dataHazard), 32'(hz));
        chk("hazard2", 32'(hif2.dataHazard), 32'(hz));
        chk("stall1", 32'(hif1.stageStall), 32'(modelStall()));
        chk("stall2", 32'(hif2.stageStall), 32'(modelStall()));
        chk("flush1", 32'(hif1.stageFlush), 32'(modelFlush(bub1)));
        chk("flush2", 32'(hif2.stageFlush), 32'(modelFlush(bub2)));
        chk("bubble1", 32'(hif1.branchBubble), 32'(rstN && bub1 > 0));
        chk("bubble2", 32'(hif2.branchBubble), 32'(rstN && bub2 > 0));
        lastHz = hif1.dataHazard;
        lastBb2 = hif2.branchBubble;
        lastStall1 = hif1.stageStall;
        lastFlush1 = hif1.stageFlush;
        lastFlush2 = hif2.stageFlush;
        @(posedge clk);
        acc = rstN && issueValid && !hz && !miss;
        if (!rstN) begin
            foreach (pend[r]) pend[r] = 0;
            bub1 = 0;
            bub2 = 0;
        end else begin
            old = pend[rd];
            foreach (pend[r]) if (pend[r] > 0) pend[r]--;
            if (acc && wen && rd != 0) begin
                nv = (old > 0) ? old - 1 : 0;
                pend[rd] = (int'(lat) - 1 > nv) ? int'(lat) - 1 : nv;
            end
            if (miss) begin
                bub1 = 0; bub2 = 0;
            end else if (pred) begin
                bub1 = B1; bub2 = B2;
            end else if (!hz) begin
                if (bub1 > 0) bub1--;
                if (bub2 > 0) bub2--;
            end
        end
        #1;
    endtask

    task automatic idle();
        issueValid = 0; rs1u = 0; rs2u = 0; wen = 0; pred = 0; miss = 0;
        rs1 = '0; rs2 = '0; rd = '0; lat = Latency'(1);
    endtask

    task automatic issueWr(input int r, input int l);
        idle();
        issueValid = 1; wen = 1; rd = RegAddr'(r); lat = Latency'(l);
    endtask

    task automatic consume(input int r);
        idle();
        issueValid = 1; rs1u = 1; rs1 = RegAddr'(r);
    endtask

    initial begin
        int n, bbHigh, fl0;
        foreach (pend[r]) pend[r] = 0;
        bub1 = 0; bub2 = 0;
        idle();
        rstN = 0;
        #1;
        cycle();
        chk("reset_flush", 32'(lastFlush1), 32'h1f);
        chk("reset_stall", 32'(lastStall1), 32'h0);
        cycle();
        rstN = 1;

        // Load-use: one stall cycle, then consumer issues.
        issueWr(5, 2); cycle();
        consume(5); cycle();
        chk("t1_hazard", 32'(lastHz), 32'd1);
        chk("t1_stall", 32'(lastStall1), 32'b00011);
        chk("t1_flush", 32'(lastFlush1), 32'b00010);
        cycle();
        chk("t1_accept", 32'(lastHz), 32'd0);

        // Long-latency producer: exactly four stall cycles.
        issueWr(7, 5); cycle();
        consume(7);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (!lastHz) break;
            n++;
        end
        chk("t2_stall_cycles", 32'(n), 32'd4);

        // r0 is never tracked.
        issueWr(0, 5); cycle();
        consume(0);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (lastHz) n++;
        end
        chk("t3_r0_hazards", 32'(n), 32'd0);

        // Mispredict overrides a live hazard and clears bubbles.
        idle(); pred = 1; cycle();
        issueWr(9, 4); cycle();
        consume(9); miss = 1; cycle();
        chk("t4_hazard", 32'(lastHz), 32'd0);
        chk("t4_flush", 32'(lastFlush1), 32'b00011);
        chk("t4_stall", 32'(lastStall1), 32'b00000);
        idle(); cycle();
        chk("t4_bubble_cleared", 32'(lastBb2), 32'd0);
        repeat (4) cycle();

        // Two bubbles with a one-cycle hazard in between.
        issueWr(11, 2); pred = 1; cycle();
        consume(11);
        bbHigh = 0; fl0 = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (lastBb2) bbHigh++;
            if (lastFlush2[0]) fl0++;
            idle();
        end
        chk("t5_bubble_cycles", 32'(bbHigh), 32'd3);
        chk("t5_fetch_squash", 32'(fl0), 32'd2);

        // Reset wipes an outstanding producer.
        issueWr(3, 5); cycle();
        idle(); rstN = 0; cycle();
        rstN = 1;
        consume(3); cycle();
        chk("t6_after_reset", 32'(lastHz), 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rstN       = ($urandom_range(0, 63) != 0);
            issueValid = ($urandom_range(0, 3) != 0);
            rs1        = RegAddr'($urandom_range(0, 7));
            rs2        = RegAddr'($urandom_range(0, 7));
            rd         = RegAddr'($urandom_range(0, 7));
            rs1u       = 1'($urandom_range(0, 1));
            rs2u       = 1'($urandom_range(0, 1));
            wen        = 1'($urandom_range(0, 1));
            lat        = Latency'($urandom_range(1, 8));
            pred       = ($urandom_range(0, 5) == 0);
            miss       = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
